// File: rtl/toy_bpu_upd_arb_pkg.sv
// Shared types for the BPU update arbiter.
//   bpu_pkg   : update payload written to the predictor tables
//   upd_src_e : which source owns the table write port (CMT=0, RAS=1, BP2=2)
package toy_pack;

   typedef struct packed {
      logic [31:0] tgt_pc;
      logic [31:0] br_pc;
      logic [1:0]  br_type;
      logic        taken;
   } bpu_pkg;

   typedef enum logic [1:0] {
      UPD_CMT = 2'd0,
      UPD_RAS = 2'd1,
      UPD_BP2 = 2'd2
   } upd_src_e;

endpackage

// File: rtl/toy_bpu_upd_fifo.sv
// Small update FIFO with wrap-bit pointers and a synchronous flush.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   flush      : empties the FIFO at the edge; a push in the same cycle is dropped
//   push/din   : enqueue (ignored when full)
//   pop        : dequeue head
//   dout       : head entry (only meaningful when !empty)
//   full/empty : occupancy flags
module toy_bpu_upd_fifo
   import toy_pack::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   input  logic   push,
   input  bpu_pkg din,
   input  logic   pop,
   output bpu_pkg dout,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB distinguishes full from empty when the index bits match.
   logic [AW:0] wptr, rptr;
   bpu_pkg      mem [DEPTH];

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + 1'b1;
         if (pop && !empty) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !flush) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/toy_bpu_upd_arb.sv
// Arbitrates three BPU update sources onto a single table write port.
// Base priority CMT > RAS > BP2; RAS/BP2 age counters promote a starved
// speculative source above CMT. A stalled grant is locked until it pops,
// except that a flush releases a locked RAS/BP2 grant.
//   clk, rst_n          : clock, async active-low reset
//   cmt_vld/rdy/pld     : commit-update source
//   ras_vld/rdy/pld     : RAS-update source (flushable)
//   bp2_vld/rdy/pld     : BP2-update source (flushable)
//   flush               : drops all queued RAS/BP2 updates
//   upd_vld/rdy/src/pld : table write-port handshake, granted source and payload
module toy_bpu_upd_arb
   import toy_pack::*;
#(
   parameter int COMMIT_DEPTH = 4,
   parameter int SPEC_DEPTH   = 2,
   parameter int AGE_MAX      = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     cmt_vld,
   output logic     cmt_rdy,
   input  bpu_pkg   cmt_pld,
   input  logic     ras_vld,
   output logic     ras_rdy,
   input  bpu_pkg   ras_pld,
   input  logic     bp2_vld,
   output logic     bp2_rdy,
   input  bpu_pkg   bp2_pld,
   input  logic     flush,
   output logic     upd_vld,
   input  logic     upd_rdy,
   output upd_src_e upd_src,
   output bpu_pkg   upd_pld
);

   localparam int AGW = $clog2(AGE_MAX) + 1;
   localparam logic [AGW-1:0] AGE_SAT = AGW'(AGE_MAX);

   logic     cmt_full, cmt_empty, ras_full, ras_empty, bp2_full, bp2_empty;
   bpu_pkg   cmt_head, ras_head, bp2_head;
   logic     pop_cmt, pop_ras, pop_bp2;
   logic [AGW-1:0] ras_age, bp2_age;
   logic     lock_vld;
   upd_src_e lock_src, grant;

   assign cmt_rdy = ~cmt_full;
   assign ras_rdy = ~ras_full;
   assign bp2_rdy = ~bp2_full;

   toy_bpu_upd_fifo #(.DEPTH(COMMIT_DEPTH)) u_cmt_fifo (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .push(cmt_vld && !cmt_full), .din(cmt_pld), .pop(pop_cmt),
      .dout(cmt_head), .full(cmt_full), .empty(cmt_empty)
   );

   toy_bpu_upd_fifo #(.DEPTH(SPEC_DEPTH)) u_ras_fifo (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .push(ras_vld && !ras_full), .din(ras_pld), .pop(pop_ras),
      .dout(ras_head), .full(ras_full), .empty(ras_empty)
   );

   toy_bpu_upd_fifo #(.DEPTH(SPEC_DEPTH)) u_bp2_fifo (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .push(bp2_vld && !bp2_full), .din(bp2_pld), .pop(pop_bp2),
      .dout(bp2_head), .full(bp2_full), .empty(bp2_empty)
   );

   assign upd_vld = !(cmt_empty && ras_empty && bp2_empty);

   // Lock first, then starvation promotion, then base priority.
   always_comb begin
      grant = UPD_CMT;
      if (lock_vld)                             grant = lock_src;
      else if (!ras_empty && ras_age == AGE_SAT) grant = UPD_RAS;
      else if (!bp2_empty && bp2_age == AGE_SAT) grant = UPD_BP2;
      else if (!cmt_empty)                       grant = UPD_CMT;
      else if (!ras_empty)                       grant = UPD_RAS;
      else if (!bp2_empty)                       grant = UPD_BP2;
   end

   assign upd_src = grant;

   always_comb begin
      upd_pld = '0;
      if (upd_vld) begin
         case (grant)
            UPD_CMT: upd_pld = cmt_head;
            UPD_RAS: upd_pld = ras_head;
            UPD_BP2: upd_pld = bp2_head;
            default: upd_pld = '0;
         endcase
      end
   end

   assign pop_cmt = upd_vld && upd_rdy && (grant == UPD_CMT);
   assign pop_ras = upd_vld && upd_rdy && (grant == UPD_RAS);
   assign pop_bp2 = upd_vld && upd_rdy && (grant == UPD_BP2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_vld <= 1'b0;
         lock_src <= UPD_CMT;
         ras_age  <= '0;
         bp2_age  <= '0;
      end else begin
         // Hold the grant while stalled; a flush invalidates a speculative grant.
         lock_vld <= upd_vld && !upd_rdy && !(flush && grant != UPD_CMT);
         lock_src <= grant;

         if (pop_ras || flush || ras_empty) ras_age <= '0;
         else if (ras_age != AGE_SAT)       ras_age <= ras_age + 1'b1;

         if (pop_bp2 || flush || bp2_empty) bp2_age <= '0;
         else if (bp2_age != AGE_SAT)       bp2_age <= bp2_age + 1'b1;
      end
   end

endmodule

// File: tb/tb_toy_bpu_upd_arb.sv
module tb_toy_bpu_upd_arb;
   import toy_pack::*;

   localparam int CD = 4;
   localparam int SD = 2;
   localparam int AM = 8;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   logic     cmt_vld, ras_vld, bp2_vld, flush, upd_rdy;
   bpu_pkg   cmt_pld, ras_pld, bp2_pld;
   logic     cmt_rdy, ras_rdy, bp2_rdy, upd_vld;
   upd_src_e upd_src;
   bpu_pkg   upd_pld;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state: plain queues, ages and a held grant.
   bpu_pkg cq[$], rq[$], bq[$];
   int     ra, ba, lsrc;
   bit     lk;

   always #5 clk = ~clk;

   toy_bpu_upd_arb #(.COMMIT_DEPTH(CD), .SPEC_DEPTH(SD), .AGE_MAX(AM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmt_vld(cmt_vld), .cmt_rdy(cmt_rdy), .cmt_pld(cmt_pld),
      .ras_vld(ras_vld), .ras_rdy(ras_rdy), .ras_pld(ras_pld),
      .bp2_vld(bp2_vld), .bp2_rdy(bp2_rdy), .bp2_pld(bp2_pld),
      .flush(flush), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
      .upd_src(upd_src), .upd_pld(upd_pld)
   );

   function automatic bpu_pkg mk(input logic [31:0] tgt);
      bpu_pkg p;
      p.tgt_pc  = tgt;
      p.br_pc   = tgt - 32'h40;
      p.br_type = tgt[3:2];
      p.taken   = tgt[4];
      return p;
   endfunction

   // -1: nothing pending; else 0=CMT, 1=RAS, 2=BP2
   function automatic int mgrant();
      if (lk)                          return lsrc;
      if (rq.size() != 0 && ra == AM)  return 1;
      if (bq.size() != 0 && ba == AM)  return 2;
      if (cq.size() != 0)              return 0;
      if (rq.size() != 0)              return 1;
      if (bq.size() != 0)              return 2;
      return -1;
   endfunction

   function automatic bpu_pkg mhead(input int g);
      case (g)
         0:       return cq[0];
         1:       return rq[0];
         2:       return bq[0];
         default: return '0;
      endcase
   endfunction

   task automatic model_clear();
      cq.delete(); rq.delete(); bq.delete();
      ra = 0; ba = 0; lk = 0; lsrc = 0;
   endtask

   // Advance the model by one clock using the inputs sampled at the edge.
   task automatic model_update();
      int  g;
      bit  v, pop, cacc, racc, bacc;
      g    = mgrant();
      v    = (g >= 0);
      pop  = v && upd_rdy;
      cacc = cmt_vld && cq.size() < CD;
      racc = ras_vld && rq.size() < SD && !flush;
      bacc = bp2_vld && bq.size() < SD && !flush;
      ra = ((pop && g == 1) || flush || rq.size() == 0) ? 0 : ((ra < AM) ? ra + 1 : AM);
      ba = ((pop && g == 2) || flush || bq.size() == 0) ? 0 : ((ba < AM) ? ba + 1 : AM);
      lk   = v && !upd_rdy && !(flush && g != 0);
      lsrc = v ? g : 0;
      if (pop) begin
         if (g == 0) void'(cq.pop_front());
         if (g == 1) void'(rq.pop_front());
         if (g == 2) void'(bq.pop_front());
      end
      if (flush) begin rq.delete(); bq.delete(); end
      if (cacc) cq.push_back(cmt_pld);
      if (racc) rq.push_back(ras_pld);
      if (bacc) bq.push_back(bp2_pld);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_update();
      else       model_clear();
      #1;
   endtask

   task automatic idle();
      cmt_vld = 0; ras_vld = 0; bp2_vld = 0; flush = 0; upd_rdy = 0;
      cmt_pld = '0; ras_pld = '0; bp2_pld = '0;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 0;
      model_clear();
      cyc();
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      cyc(); cyc();
      n_chk++;
      if ({upd_vld, cmt_rdy, ras_rdy, bp2_rdy} !== 4'b0111)
         $display("FAIL reset_flags got %b exp 0111", {upd_vld, cmt_rdy, ras_rdy, bp2_rdy});
      else n_pass++;
      n_chk++;
      if ({upd_src, upd_pld} !== {UPD_CMT, bpu_pkg'('0)})
         $display("FAIL reset_out got src %0d pld %h exp 0/0", upd_src, upd_pld);
      else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_basic();
      apply_reset();
      upd_rdy = 1;
      cmt_vld = 1; cmt_pld = mk(32'h8000_0040);
      ras_vld = 1; ras_pld = mk(32'h8000_0100);
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL basic_no_bypass got %b exp 0", upd_vld);
      else n_pass++;
      cyc();
      cmt_vld = 0; ras_vld = 0;
      n_chk++;
      if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_CMT, mk(32'h8000_0040)})
         $display("FAIL basic_cmt got %b/%0d/%h", upd_vld, upd_src, upd_pld.tgt_pc);
      else n_pass++;
      cyc();
      n_chk++;
      if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_RAS, mk(32'h8000_0100)})
         $display("FAIL basic_ras got %b/%0d/%h", upd_vld, upd_src, upd_pld.tgt_pc);
      else n_pass++;
      cyc();
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL basic_drained got %b exp 0", upd_vld);
      else n_pass++;
   endtask

   task automatic test_age();
      upd_src_e exp;
      apply_reset();
      upd_rdy = 1;
      cmt_vld = 1; cmt_pld = mk(32'h8000_1000);
      ras_vld = 1; ras_pld = mk(32'h8000_2000);
      cyc();
      ras_vld = 0;
      for (int k = 1; k <= 10; k++) begin
         exp = (k == 9) ? UPD_RAS : UPD_CMT;
         n_chk++;
         if (upd_src !== exp) $display("FAIL age_src k=%0d got %0d exp %0d", k, upd_src, exp);
         else n_pass++;
         if (k == 9) begin
            n_chk++;
            if (upd_pld !== mk(32'h8000_2000)) $display("FAIL age_pld got %h exp 80002000", upd_pld.tgt_pc);
            else n_pass++;
         end
         cyc();
      end
      idle();
   endtask

   task automatic test_lock();
      apply_reset();
      bp2_vld = 1; bp2_pld = mk(32'h8000_3000);
      cyc();
      bp2_vld = 0;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_BP2, mk(32'h8000_3000)})
            $display("FAIL lock_hold i=%0d got %0d/%h exp 2/80003000", i, upd_src, upd_pld.tgt_pc);
         else n_pass++;
         cyc();
      end
      cmt_vld = 1; cmt_pld = mk(32'h8000_3100);
      cyc();
      cmt_vld = 0;
      n_chk++;
      if ({upd_src, upd_pld} !== {UPD_BP2, mk(32'h8000_3000)})
         $display("FAIL lock_after_cmt got %0d/%h exp 2/80003000", upd_src, upd_pld.tgt_pc);
      else n_pass++;
      upd_rdy = 1;
      cyc();
      n_chk++;
      if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_CMT, mk(32'h8000_3100)})
         $display("FAIL lock_release got %0d/%h exp 0/80003100", upd_src, upd_pld.tgt_pc);
      else n_pass++;
      cyc();
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL lock_drained got %b exp 0", upd_vld);
      else n_pass++;
      idle();
   endtask

   task automatic test_flush();
      apply_reset();
      bp2_vld = 1; bp2_pld = mk(32'h8000_4000);
      cyc();
      bp2_pld = mk(32'h8000_4010);
      ras_vld = 1; ras_pld = mk(32'h8000_4100);
      cmt_vld = 1; cmt_pld = mk(32'h8000_4200);
      cyc();
      bp2_vld = 0; cmt_vld = 0; ras_pld = mk(32'h8000_4110);
      cyc();
      ras_vld = 0;
      n_chk++;
      if ({ras_rdy, bp2_rdy, cmt_rdy} !== 3'b001)
         $display("FAIL flush_pre_rdy got %b exp 001", {ras_rdy, bp2_rdy, cmt_rdy});
      else n_pass++;
      n_chk++;
      if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_BP2, mk(32'h8000_4000)})
         $display("FAIL flush_pre_grant got %0d/%h exp 2/80004000", upd_src, upd_pld.tgt_pc);
      else n_pass++;
      flush = 1;
      cyc();
      flush = 0;
      n_chk++;
      if ({ras_rdy, bp2_rdy} !== 2'b11) $display("FAIL flush_rdy got %b exp 11", {ras_rdy, bp2_rdy});
      else n_pass++;
      n_chk++;
      if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_CMT, mk(32'h8000_4200)})
         $display("FAIL flush_regrant got %0d/%h exp 0/80004200", upd_src, upd_pld.tgt_pc);
      else n_pass++;
      upd_rdy = 1;
      cyc();
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL flush_no_bp2 got %b exp 0", upd_vld);
      else n_pass++;
      // enqueue in the flush cycle is dropped
      flush = 1; ras_vld = 1; bp2_vld = 1;
      cyc();
      idle();
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL flush_enq_drop got %b exp 0", upd_vld);
      else n_pass++;
   endtask

   task automatic test_cmt_full();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cmt_vld = 1; cmt_pld = mk(32'h8000_5000 + 32'(i * 4));
         n_chk++;
         if (cmt_rdy !== 1'b1) $display("FAIL full_fill_rdy i=%0d got %b exp 1", i, cmt_rdy);
         else n_pass++;
         cyc();
      end
      cmt_pld = mk(32'h8000_5010);
      n_chk++;
      if (cmt_rdy !== 1'b0) $display("FAIL full_rdy got %b exp 0", cmt_rdy);
      else n_pass++;
      cyc();
      cmt_vld = 0;
      n_chk++;
      if ({cmt_rdy, upd_pld} !== {1'b0, mk(32'h8000_5000)})
         $display("FAIL full_stall got %b/%h exp 0/80005000", cmt_rdy, upd_pld.tgt_pc);
      else n_pass++;
      upd_rdy = 1;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({upd_vld, upd_src, upd_pld} !== {1'b1, UPD_CMT, mk(32'h8000_5000 + 32'(i * 4))})
            $display("FAIL full_drain i=%0d got %h exp %h", i, upd_pld.tgt_pc, 32'h8000_5000 + 32'(i * 4));
         else n_pass++;
         cyc();
         if (i == 0) begin
            n_chk++;
            if (cmt_rdy !== 1'b1) $display("FAIL full_rdy_after_pop got %b exp 1", cmt_rdy);
            else n_pass++;
         end
      end
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL full_5th_dropped got %b exp 0", upd_vld);
      else n_pass++;
      cmt_vld = 1; cmt_pld = mk(32'h8000_5020);
      cyc();
      cmt_vld = 0;
      n_chk++;
      if ({upd_vld, upd_pld} !== {1'b1, mk(32'h8000_5020)})
         $display("FAIL full_wrap got %b/%h exp 1/80005020", upd_vld, upd_pld.tgt_pc);
      else n_pass++;
      cyc();
      idle();
   endtask

   task automatic test_async_reset();
      apply_reset();
      cmt_vld = 1; cmt_pld = mk(32'h8000_6000);
      ras_vld = 1; ras_pld = mk(32'h8000_6100);
      bp2_vld = 1; bp2_pld = mk(32'h8000_6200);
      cyc();
      idle();
      n_chk++;
      if (upd_vld !== 1'b1) $display("FAIL areset_pre got %b exp 1", upd_vld);
      else n_pass++;
      #2 rst_n = 0;
      #1;
      n_chk++;
      if ({upd_vld, cmt_rdy, ras_rdy, bp2_rdy} !== 4'b0111)
         $display("FAIL areset_flags got %b exp 0111", {upd_vld, cmt_rdy, ras_rdy, bp2_rdy});
      else n_pass++;
      n_chk++;
      if ({upd_src, upd_pld} !== {UPD_CMT, bpu_pkg'('0)})
         $display("FAIL areset_out got %0d/%h exp 0/0", upd_src, upd_pld);
      else n_pass++;
      cyc();
      rst_n = 1;
      n_chk++;
      if (upd_vld !== 1'b0) $display("FAIL areset_dropped got %b exp 0", upd_vld);
      else n_pass++;
   endtask

   task automatic test_random();
      int     g;
      bpu_pkg ep;
      apply_reset();
      for (int c = 0; c < 500; c++) begin
         cmt_vld = ($urandom_range(0, 99) < 40);
         ras_vld = ($urandom_range(0, 99) < 35);
         bp2_vld = ($urandom_range(0, 99) < 35);
         flush   = ($urandom_range(0, 99) < 5);
         upd_rdy = ($urandom_range(0, 99) < 55);
         cmt_pld = mk($urandom);
         ras_pld = mk($urandom);
         bp2_pld = mk($urandom);
         g  = mgrant();
         ep = (g >= 0) ? mhead(g) : bpu_pkg'('0);
         n_chk++;
         if (upd_vld !== (g >= 0)) $display("FAIL rnd_vld c=%0d got %b exp %b", c, upd_vld, g >= 0);
         else n_pass++;
         n_chk++;
         if (upd_src !== upd_src_e'((g >= 0) ? g : 0))
            $display("FAIL rnd_src c=%0d got %0d exp %0d", c, upd_src, (g >= 0) ? g : 0);
         else n_pass++;
         n_chk++;
         if (upd_pld !== ep) $display("FAIL rnd_pld c=%0d got %h exp %h", c, upd_pld, ep);
         else n_pass++;
         n_chk++;
         if ({cmt_rdy, ras_rdy, bp2_rdy} !== {cq.size() < CD, rq.size() < SD, bq.size() < SD})
            $display("FAIL rnd_rdy c=%0d got %b exp %b", c, {cmt_rdy, ras_rdy, bp2_rdy},
                     {cq.size() < CD, rq.size() < SD, bq.size() < SD});
         else n_pass++;
         cyc();
      end
      idle();
   endtask

   initial begin
      idle();
      model_clear();
      test_reset();
      test_basic();
      test_age();
      test_lock();
      test_flush();
      test_cmt_full();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
